// File: rtl/banked_main_mem.sv
// Four-bank word memory with per-bank occupancy counters and a two-stage read-return pipeline.
// Each bank accepts one access, then stays busy for BUSY_CYCLES-1 further cycles.
module banked_main_mem #(
    parameter int unsigned BUSY_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LOAD = CW'(BUSY_CYCLES - 1);

    logic [15:0]   mem [4][8192];
    logic [CW-1:0] cnt [4];

    logic [1:0]  bank;
    logic [12:0] row;
    logic        req;
    logic        accept;

    logic        v1, v2;
    logic [15:0] d1, d2;

    always_comb begin
        bank   = addr[2:1];
        row    = addr[15:3];
        req    = rd | wr;
        err    = req & (addr[0] | (rd & wr));
        stall  = req & ~err & busy[bank];
        accept = req & ~err & ~busy[bank];
    end

    always_comb begin
        busy = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            busy[b] = (cnt[b] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (accept && (bank == 2'(b))) begin
                    cnt[b] <= LOAD;
                end else if (cnt[b] != '0) begin
                    cnt[b] <= cnt[b] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                for (int unsigned r = 0; r < 8192; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (accept && wr) begin
            mem[bank][row] <= data_in;
        end
    end

    // d1 samples the array before this edge's write lands, so a read never sees a later write.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            v1 <= accept & rd;
            d1 <= mem[bank][row];
            v2 <= v1;
            d2 <= d1;
        end
    end

    assign data_out = v2 ? d2 : '0;

endmodule
